// File: rtl/matmul_sequencer_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// State encoding and width helpers used by the top and its delay line.
package matmul_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Shift register of {valid, idx} tags with asynchronous reset.
// pending reports valid tags that will still be in flight after the next edge.
module tag_delay_line #(
  parameter int DEPTH = 3,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [IW-1:0] in_idx,
  output logic          out_vld,
  output logic [IW-1:0] out_idx,
  output logic          pending
);

  logic [DEPTH-1:0] vld_q;
  logic [IW-1:0]    idx_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++)
        idx_q[k] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++)
      pending = pending | vld_q[k];
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences row/column vector pairs into an external vec_dot and
// collects the returned dot products into the C matrix.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int EXP_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 23,
  parameter int VEC_SIZE    = 4,
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DOT_LATENCY = 3,
  localparam int FW = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int VW = VEC_SIZE * FW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROWS*VW-1:0]       a_mat,
  input  logic [COLS*VW-1:0]       b_mat,
  output logic [VW-1:0]            lhs,
  output logic [VW-1:0]            rhs,
  input  logic [FW-1:0]            dot_res,
  output logic [ROWS*COLS*FW-1:0]  c_mat,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = clog2_min1(ROWS);
  localparam int JW = clog2_min1(COLS);
  localparam int XW = clog2_min1(ROWS * COLS);

  state_t state_q, state_n;

  logic [ROWS*VW-1:0] a_q;
  logic [COLS*VW-1:0] b_q;
  logic [IW-1:0]      i_q;
  logic [JW-1:0]      j_q;
  logic               iss_vld;
  logic [XW-1:0]      iss_idx;
  logic               out_vld;
  logic [XW-1:0]      out_idx;
  logic               dl_pending;
  logic               capture;
  logic               issue;
  logic               last_j;
  logic               last_i;
  logic [VW-1:0]      row_vec;
  logic [VW-1:0]      col_vec;

  assign last_j  = (j_q == JW'(COLS - 1));
  assign last_i  = (i_q == IW'(ROWS - 1));
  assign row_vec = a_q[int'(i_q)*VW +: VW];

  // B is row-major, so column j is strided by COLS elements
  always_comb begin
    col_vec = '0;
    for (int k = 0; k < VEC_SIZE; k++)
      col_vec[k*FW +: FW] = b_q[(k*COLS + int'(j_q))*FW +: FW];
  end

  always_comb begin
    state_n = state_q;
    capture = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          capture = 1'b1;
          state_n = ISSUE;
        end else if (state_q == DONE) begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_i && last_j)
          state_n = DRAIN;
      end
      DRAIN: begin
        // leave once the tag emerging on this edge is the last one
        if (!iss_vld && !dl_pending)
          state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else if (capture) begin
      a_q <= a_mat;
      b_q <= b_mat;
      i_q <= '0;
      j_q <= '0;
    end else if (issue) begin
      j_q <= last_j ? '0 : j_q + 1'b1;
      if (last_j && !last_i)
        i_q <= i_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhs     <= '0;
      rhs     <= '0;
      iss_vld <= 1'b0;
      iss_idx <= '0;
    end else begin
      iss_vld <= issue;
      if (issue) begin
        lhs     <= row_vec;
        rhs     <= col_vec;
        iss_idx <= XW'(int'(i_q) * COLS + int'(j_q));
      end
    end
  end

  tag_delay_line #(
    .DEPTH (DOT_LATENCY),
    .IW    (XW)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (iss_vld),
    .in_idx  (iss_idx),
    .out_vld (out_vld),
    .out_idx (out_idx),
    .pending (dl_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      c_mat <= '0;
    else if (out_vld)
      c_mat[int'(out_idx)*FW +: FW] <= dot_res;
  end

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: 4x4/L3 instance with a
// behavioural vec_dot, plus a 1x1/L1 boundary instance.
module tb_matmul_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] a_mat;
  logic [511:0] b_mat;
  logic [127:0] lhs;
  logic [127:0] rhs;
  logic [31:0]  dot_res;
  logic [511:0] c_mat;
  logic         busy;
  logic         done;

  logic         start1;
  logic [31:0]  a1;
  logic [31:0]  b1;
  logic [31:0]  lhs1;
  logic [31:0]  rhs1;
  logic [31:0]  dot1;
  logic [31:0]  c1;
  logic         busy1;
  logic         done1;

  bit           mode;
  logic [31:0]  p0, p1, p2;
  int           tests = 0;
  int           errors = 0;

  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    bit           mode;
    bit           busy_starts;
    logic [511:0] expc;
  } vec_t;

  vec_t tbl [3];

  always #5 clk = ~clk;

  matmul_sequencer u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_mat   (a_mat),
    .b_mat   (b_mat),
    .lhs     (lhs),
    .rhs     (rhs),
    .dot_res (dot_res),
    .c_mat   (c_mat),
    .busy    (busy),
    .done    (done)
  );

  matmul_sequencer #(
    .VEC_SIZE    (1),
    .ROWS        (1),
    .COLS        (1),
    .DOT_LATENCY (1)
  ) u_one (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .a_mat   (a1),
    .b_mat   (b1),
    .lhs     (lhs1),
    .rhs     (rhs1),
    .dot_res (dot1),
    .c_mat   (c1),
    .busy    (busy1),
    .done    (done1)
  );

  // behavioural vec_dot: mode 0 picks rhs[k] where lhs[k]==1.0,
  // mode 1 is an order-sensitive integer mix
  function automatic logic [31:0] dot_model(
    input logic [127:0] l, input logic [127:0] r, input bit m);
    logic [31:0] acc;
    acc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (m)
        acc = acc + (l[k*32 +: 32] + 32'(3*k)) * (r[k*32 +: 32] | 32'h1);
      else if (l[k*32 +: 32] == 32'h3F800000)
        acc = r[k*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [511:0] hash_c(
    input logic [511:0] a, input logic [511:0] b);
    logic [511:0] c;
    logic [31:0]  acc;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 32'h0;
        for (int k = 0; k < 4; k++)
          acc = acc + (a[(i*4+k)*32 +: 32] + 32'(3*k))
                    * (b[(k*4+j)*32 +: 32] | 32'h1);
        c[(i*4+j)*32 +: 32] = acc;
      end
    return c;
  endfunction

  always @(posedge clk) begin
    p0 <= dot_model(lhs, rhs, mode);
    p1 <= p0;
    p2 <= p1;
    dot1 <= (lhs1 == 32'h40000000 && rhs1 == 32'h40400000)
            ? 32'h40C00000 : 32'hDEADBEEF;
  end
  assign dot_res = p2;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_run(input vec_t v, input bit chained,
                        input logic [511:0] prev_c);
    int n;
    int r;
    int cc;
    bit seen;
    bit io_bad;
    bit busy_bad;
    logic [127:0] el;
    logic [127:0] er;
    mode  = v.mode;
    a_mat = v.a;
    b_mat = v.b;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a_mat    = ~v.a;
    b_mat    = ~v.b;
    n        = 0;
    seen     = 1'b0;
    io_bad   = 1'b0;
    busy_bad = !busy;
    if (chained) chk("hold_prev", c_mat, prev_c);
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      start = v.busy_starts && (n == 5 || n == 18);
      if (n >= 1 && n <= 16) begin
        r  = (n - 1) / 4;
        cc = (n - 1) % 4;
        el = v.a[r*128 +: 128];
        for (int k = 0; k < 4; k++)
          er[k*32 +: 32] = v.b[(k*4 + cc)*32 +: 32];
        if (lhs !== el || rhs !== er) io_bad = 1'b1;
      end
      if (chained && n == 4) chk("hold_until_write", c_mat, prev_c);
      if (done) seen = 1'b1;
      else if (!busy) busy_bad = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 512'(seen), 512'd1);
    chk("latency", 512'(n), 512'd20);
    chk("busy_span", 512'(busy_bad), 512'd0);
    chk("busy_drop", 512'(busy), 512'd0);
    chk("lhs_rhs_order", 512'(io_bad), 512'd0);
    chk("c_mat", c_mat, v.expc);
  endtask

  task automatic post_idle();
    @(negedge clk);
    chk("single_done", 512'(done), 512'd0);
    chk("idle_busy", 512'(busy), 512'd0);
  endtask

  initial begin
    logic [31:0]  fl [16];
    logic [511:0] bfl;
    logic [511:0] ident;
    logic [511:0] perm;
    logic [511:0] pexp;
    logic [511:0] ha;
    logic [511:0] hb;
    bit           bad;
    int           n;

    fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
           32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
           32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    bfl = '0; ident = '0; perm = '0; pexp = '0; ha = '0; hb = '0;
    for (int e = 0; e < 16; e++) begin
      bfl[e*32 +: 32] = fl[e];
      ha[e*32 +: 32]  = 32'h01010101 * 32'(e + 1);
      hb[e*32 +: 32]  = 32'h13579BDF ^ (32'h00112233 * 32'(e));
    end
    for (int i = 0; i < 4; i++) begin
      ident[(i*4 + i)*32 +: 32]           = 32'h3F800000;
      perm[(i*4 + (i+1)%4)*32 +: 32]      = 32'h3F800000;
      for (int j = 0; j < 4; j++)
        pexp[(i*4 + j)*32 +: 32] = fl[((i+1)%4)*4 + j];
    end
    tbl[0] = '{a: ident, b: bfl, mode: 1'b0, busy_starts: 1'b0, expc: bfl};
    tbl[1] = '{a: perm,  b: bfl, mode: 1'b0, busy_starts: 1'b1, expc: pexp};
    tbl[2] = '{a: ha,    b: hb,  mode: 1'b1, busy_starts: 1'b0,
               expc: hash_c(ha, hb)};

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    a_mat = '0; b_mat = '0; a1 = '0; b1 = '0; mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_lhs", 512'(lhs), 512'd0);
    chk("rst_rhs", 512'(rhs), 512'd0);
    chk("rst_c", c_mat, 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_done", 512'(done), 512'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      do_run(tbl[t], 1'b0, '0);
      post_idle();
    end

    // back-to-back: second start lands in the DONE cycle
    do_run(tbl[1], 1'b0, '0);
    do_run(tbl[2], 1'b1, tbl[1].expc);
    post_idle();

    // reset in ISSUE while row 2 is on lhs
    mode = 1'b1; a_mat = ha; b_mat = hb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 512'(busy), 512'd0);
    chk("mid_rst_done", 512'(done), 512'd0);
    chk("mid_rst_c", c_mat, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (c_mat !== '0 || done || busy) bad = 1'b1;
    end
    chk("no_write_after_rst", 512'(bad), 512'd0);
    do_run(tbl[2], 1'b0, '0);
    post_idle();

    // 1x1 boundary with single-cycle dot latency
    a1 = 32'h40000000; b1 = 32'h40400000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("one_latency", 512'(n), 512'd3);
    chk("one_c", 512'(c1), 512'h40C00000);
    @(negedge clk);
    chk("one_single_done", 512'(done1), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Drives an external vec_dot instance to compute C = A x B for small float matrices.
- A is ROWS x VEC_SIZE and B is VEC_SIZE x COLS; both are captured on start.
- Issues one (row, column) vector pair per cycle on lhs/rhs and tracks each issue through a tag delay line that matches the dot-product latency.
- Writes each returned res into the C buffer and signals completion.

Parameters:
- EXP_WIDTH, 8, float exponent bits.
- FRAC_WIDTH, 23, float fraction bits. FLOAT_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH.
- VEC_SIZE, 4, inner dimension; must equal the VEC_SIZE of the vec_dot being driven.
- ROWS, 4, rows of A and C; >= 1.
- COLS, 4, columns of B and C; >= 1.
- DOT_LATENCY, 3, clk edges from lhs/rhs valid to the matching dot_res valid; >= 1.

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- a_mat  in  ROWS*VEC_SIZE*FLOAT_WIDTH  A, row-major; element 0 in the LSBs.
- b_mat  in  VEC_SIZE*COLS*FLOAT_WIDTH  B, row-major; element 0 in the LSBs.
- lhs  out  VEC_SIZE*FLOAT_WIDTH  row i of A, to vec_dot lhs.
- rhs  out  VEC_SIZE*FLOAT_WIDTH  column j of B, gathered into vector order (element k = B[k][j]).
- dot_res  in  FLOAT_WIDTH  from vec_dot res.
- c_mat  out  ROWS*COLS*FLOAT_WIDTH  C, row-major; registered.
- busy  out  1  high from the cycle after an accepted start until the last write.
- done  out  1  one-cycle pulse after the final C element is written.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - A/B capture registers, c_mat, the counters and every delay-line valid bit are cleared to 0.
  - lhs=0, rhs=0, busy=0, done=0.
- Reset during any state aborts the operation. No writes occur after reset asserts.
- State IDLE/DONE, start=1:
  - Capture a_mat and b_mat.
  - Set counters i=0, j=0.
  - Go to ISSUE.
  - c_mat holds its previous contents until overwritten element by element.
- State ISSUE, each cycle:
  - lhs/rhs are registered from the captured A row i and B column j.
  - Push tag {valid=1, idx=i*COLS+j} into the delay line.
  - Advance j; on j==COLS-1, wrap j to 0 and increment i.
  - After issuing (ROWS-1, COLS-1), go to DRAIN.
  - Exactly ROWS*COLS issue cycles occur.
- Delay line:
  - DOT_LATENCY stages, aligned so that a tag emerges in the same cycle its dot_res is valid. The delay counts from the register that drives lhs/rhs.
  - A bubble (valid=0) is pushed in every non-ISSUE cycle.
- Write-back: when the emerging tag has valid=1, c_mat[idx] <= dot_res on that edge.
- State DRAIN: wait until the delay line holds no valid tags, then go to DONE with done=1 for exactly one cycle.
- State DONE: returns to IDLE the next cycle, unless start=1, which restarts as from IDLE.
- Start handling:
  - start in ISSUE or DRAIN is ignored; it is neither queued nor does it corrupt the operation.
  - a_mat/b_mat may change freely after the capture cycle.
- Total latency: start edge to done pulse = ROWS*COLS + DOT_LATENCY + 1 cycles.
- Counter widths: $clog2 of the matching dimension, minimum 1. idx width is $clog2(ROWS*COLS), minimum 1.
- ROWS=COLS=1 is a single issue cycle and must work.
- No floating-point arithmetic is done here; values pass through bit-exact.

Decomposition:
- Add FLOAT_WIDTH, VEC_WIDTH(n), VEC_SELECT(i) and a new MAT_SELECT(r,c,ncols) to the shared vec macros header.
- The parameter list follows the existing VEC_PARAMS group, extended with ROWS, COLS and DOT_LATENCY.
- One sub-module is natural: tag_delay_line, a parameterised shift register of {valid, idx} with async reset.
- The column gather of B and the FSM stay in matmul_sequencer.
- The top-level matmul instantiates matmul_sequencer plus vec_dot, with DOT_LATENCY set from vec_dot's pipeline depth.

Test Plan:
- Identity case (1.0=32'h3F800000): A = I4, B = {1.0..16.0}, start -> c_mat == B bit-exact; done exactly 4*4+3+1=20 cycles after start.
- Ordering check: drive dot_res from a behavioural model returning a tag-unique constant -> each c_mat element lands at the correct idx, and rhs shows B column gather order (rhs[k]=B[k][j]).
- Busy start: start while busy, at cycles 5 and 18 -> ignored; single done pulse; results unchanged; busy drops together with the final write.
- Reset mid-operation: assert rst for 1 cycle in ISSUE at i=2 -> immediately busy=0, done=0, c_mat=0; in-flight dot_res values are never written; a fresh start then completes correctly.
- Boundary, ROWS=COLS=1, DOT_LATENCY=1: A={2.0}, B={3.0} with model dot_res=6.0 (32'h40C00000) -> c_mat=32'h40C00000; done 3 cycles after start.
- Back-to-back: start asserted in the DONE cycle -> new capture and new run; second done pulse 20 cycles later; the first run's results stay visible until overwritten.
